// File: rtl/dclab_game_pkg.sv
// Shared types and constants for the match controller: FSM state encoding,
// PS/2 make codes, winner codes and the line-clear attack table.
package dclab_game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_PLAY      = 3'd2,
        ST_PAUSE     = 3'd3,
        ST_OVER      = 3'd4
    } state_t;

    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_ENTER = 8'h5A;
    localparam logic [7:0] KEY_ESC   = 8'h76;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    // Garbage lines sent to the opponent for a given number of cleared lines.
    function automatic logic [2:0] attack_lines(input logic [2:0] lines);
        case (lines)
            3'd2:    attack_lines = 3'd1;
            3'd3:    attack_lines = 3'd2;
            3'd4:    attack_lines = 3'd4;
            default: attack_lines = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/garbage_queue.sv
// Pending-garbage counter for one player. An own attack first cancels pending
// lines; whatever is left over is reported on o_remain for the opponent's queue.
// Incoming lines add, an ack removes one, and the result saturates at MAX_PENDING.
module garbage_queue
#(
    parameter int MAX_PENDING = 15
)
(
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic                                 i_clr,
    input  logic [2:0]                           i_attack,
    input  logic [2:0]                           i_incoming,
    input  logic                                 i_ack,
    output logic [$clog2(MAX_PENDING+1)-1:0]     o_count,
    output logic [2:0]                           o_remain
);

    localparam int QW = $clog2(MAX_PENDING + 1);
    localparam int SW = QW + 3;
    localparam logic [SW-1:0] MAX_EXT = SW'(MAX_PENDING);

    logic [SW-1:0] q_ext;
    logic [SW-1:0] atk_ext;
    logic [SW-1:0] inc_ext;
    logic [SW-1:0] cancel;
    logic [SW-1:0] total;

    // Next queue value: cancel, add incoming, net the ack, then saturate.
    always_comb begin
        q_ext    = SW'(o_count);
        atk_ext  = SW'(i_attack);
        inc_ext  = SW'(i_incoming);
        cancel   = (atk_ext > q_ext) ? q_ext : atk_ext;
        o_remain = (atk_ext > q_ext) ? 3'(atk_ext - q_ext) : 3'd0;
        total    = q_ext - cancel + inc_ext;
        if (i_ack && (total != '0)) begin
            total = total - 1'b1;
        end
        if (total > MAX_EXT) begin
            total = MAX_EXT;
        end
    end

    // Queue register, cleared at the start of every match.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_count <= '0;
        end else if (i_clr) begin
            o_count <= '0;
        end else begin
            o_count <= QW'(total);
        end
    end

endmodule

// File: rtl/match_ctrl.sv
// Match controller: countdown, play/pause/over sequencing, winner decision
// and the two cross-linked garbage queues of versus mode.
module match_ctrl
    import dclab_game_pkg::*;
#(
    parameter int TICK_CYCLES = 50_000_000,
    parameter int COUNTDOWN   = 3,
    parameter int MAX_PENDING = 15
)
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_key,
    input  logic        i_key_valid,
    input  logic        i_go,
    input  logic        i_mode,
    input  logic [2:0]  i_lines_1,
    input  logic [2:0]  i_lines_2,
    input  logic        i_lines_valid_1,
    input  logic        i_lines_valid_2,
    input  logic        i_over_1,
    input  logic        i_over_2,
    input  logic        i_garbage_ack_1,
    input  logic        i_garbage_ack_2,
    output logic        o_start,
    output logic        o_pause,
    output logic        o_garbage_req_1,
    output logic        o_garbage_req_2,
    output logic [2:0]  o_state,
    output logic [1:0]  o_count,
    output logic [1:0]  o_winner
);

    localparam int QW = $clog2(MAX_PENDING + 1);
    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [1:0]    CD_START  = 2'(COUNTDOWN);

    state_t        state;
    logic          mode;
    logic [TW-1:0] tick;
    logic [QW-1:0] queue_1;
    logic [QW-1:0] queue_2;
    logic [2:0]    remain_1;
    logic [2:0]    remain_2;
    logic [2:0]    atk_1;
    logic [2:0]    atk_2;
    logic          versus_play;
    logic          play;
    logic          clr;
    logic          esc_key;
    logic          enter_key;
    logic          over_1;
    logic          over_2;

    assign play        = (state == ST_PLAY);
    assign versus_play = play && mode;
    assign clr         = (state == ST_IDLE) && i_go;
    assign esc_key     = i_key_valid && (i_key == KEY_ESC);
    assign enter_key   = i_key_valid && (i_key == KEY_ENTER);
    assign over_1      = i_over_1;
    assign over_2      = i_over_2 && mode;

    // Attacks only exist during a versus match; elsewhere they are dropped.
    assign atk_1 = (versus_play && i_lines_valid_1) ? attack_lines(i_lines_1) : 3'd0;
    assign atk_2 = (versus_play && i_lines_valid_2) ? attack_lines(i_lines_2) : 3'd0;

    // Each queue's leftover attack feeds the other; both use pre-cycle values.
    garbage_queue #(.MAX_PENDING(MAX_PENDING)) u_queue_1 (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (clr),
        .i_attack   (atk_1),
        .i_incoming (remain_2),
        .i_ack      (i_garbage_ack_1 && versus_play),
        .o_count    (queue_1),
        .o_remain   (remain_1)
    );

    garbage_queue #(.MAX_PENDING(MAX_PENDING)) u_queue_2 (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (clr),
        .i_attack   (atk_2),
        .i_incoming (remain_1),
        .i_ack      (i_garbage_ack_2 && versus_play),
        .o_count    (queue_2),
        .o_remain   (remain_2)
    );

    assign o_garbage_req_1 = (queue_1 != '0) && versus_play;
    assign o_garbage_req_2 = (queue_2 != '0) && versus_play;
    assign o_state         = state;

    // Match sequencing with the countdown tick counter and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            mode     <= 1'b0;
            tick     <= '0;
            o_start  <= 1'b0;
            o_pause  <= 1'b0;
            o_count  <= 2'd0;
            o_winner <= WIN_NONE;
        end else begin
            o_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_go) begin
                        state    <= ST_COUNTDOWN;
                        mode     <= i_mode;
                        o_winner <= WIN_NONE;
                        o_count  <= CD_START;
                        tick     <= '0;
                        o_pause  <= 1'b1;
                    end
                end
                ST_COUNTDOWN: begin
                    if (tick == TICK_LAST) begin
                        tick <= '0;
                        if (o_count == 2'd1) begin
                            state   <= ST_PLAY;
                            o_count <= 2'd0;
                            o_start <= 1'b1;
                            o_pause <= 1'b0;
                        end else begin
                            o_count <= o_count - 2'd1;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (over_1 || over_2) begin
                        state   <= ST_OVER;
                        o_pause <= 1'b1;
                        if (!mode) begin
                            o_winner <= WIN_NONE;
                        end else if (over_1 && over_2) begin
                            o_winner <= WIN_DRAW;
                        end else if (over_1) begin
                            o_winner <= WIN_P2;
                        end else begin
                            o_winner <= WIN_P1;
                        end
                    end else if (esc_key) begin
                        state   <= ST_PAUSE;
                        o_pause <= 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (enter_key) begin
                        state   <= ST_PLAY;
                        o_pause <= 1'b0;
                    end else if (esc_key) begin
                        state   <= ST_IDLE;
                        o_pause <= 1'b0;
                    end
                end
                ST_OVER: begin
                    if (enter_key) begin
                        state   <= ST_IDLE;
                        o_pause <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    o_pause <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_match_ctrl.sv
// Directed bench for match_ctrl with a 4-cycle tick and a 3-count countdown.
module tb_match_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] key = 8'h00;
    logic       key_valid = 1'b0;
    logic       go = 1'b0;
    logic       mode = 1'b0;
    logic [2:0] lines_1 = 3'd0;
    logic [2:0] lines_2 = 3'd0;
    logic       lv_1 = 1'b0;
    logic       lv_2 = 1'b0;
    logic       over_1 = 1'b0;
    logic       over_2 = 1'b0;
    logic       ack_1 = 1'b0;
    logic       ack_2 = 1'b0;
    logic       start;
    logic       pause;
    logic       req_1;
    logic       req_2;
    logic [2:0] state;
    logic [1:0] count;
    logic [1:0] winner;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    match_ctrl #(.TICK_CYCLES(4), .COUNTDOWN(3), .MAX_PENDING(15)) u_dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_key           (key),
        .i_key_valid     (key_valid),
        .i_go            (go),
        .i_mode          (mode),
        .i_lines_1       (lines_1),
        .i_lines_2       (lines_2),
        .i_lines_valid_1 (lv_1),
        .i_lines_valid_2 (lv_2),
        .i_over_1        (over_1),
        .i_over_2        (over_2),
        .i_garbage_ack_1 (ack_1),
        .i_garbage_ack_2 (ack_2),
        .o_start         (start),
        .o_pause         (pause),
        .o_garbage_req_1 (req_1),
        .o_garbage_req_2 (req_2),
        .o_state         (state),
        .o_count         (count),
        .o_winner        (winner)
    );

    // Advance one clock and settle 1 time unit past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        key = 8'h00; key_valid = 1'b0; go = 1'b0;
        lv_1 = 1'b0; lv_2 = 1'b0; over_1 = 1'b0; over_2 = 1'b0;
        ack_1 = 1'b0; ack_2 = 1'b0;
    endtask

    task automatic press(input logic [7:0] k);
        key = k; key_valid = 1'b1;
        step();
        clear_inputs();
    endtask

    task automatic lines(input logic v1, input logic [2:0] n1,
                         input logic v2, input logic [2:0] n2);
        lv_1 = v1; lines_1 = n1; lv_2 = v2; lines_2 = n2;
        step();
        clear_inputs();
    endtask

    // Go from IDLE to PLAY: 1 go cycle plus 12 countdown cycles.
    task automatic start_match(input logic m);
        go = 1'b1; mode = m;
        step();
        clear_inputs();
        repeat (12) step();
        n_cmp++;
        if (state !== 3'd2) begin
            n_fail++; $display("FAIL start_match state got %0d want 2", state);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_cmp++;
        if ({state, count, winner, start, pause, req_1, req_2} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset outputs got st=%0d cnt=%0d win=%0d start=%0b pause=%0b req=%0b%0b want all 0",
                     state, count, winner, start, pause, req_1, req_2);
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_countdown();
        go = 1'b1; mode = 1'b1;
        step();
        clear_inputs();
        n_cmp++;
        if (state !== 3'd1 || count !== 2'd3 || pause !== 1'b1) begin
            n_fail++; $display("FAIL countdown_entry got st=%0d cnt=%0d pause=%0b want 1/3/1", state, count, pause);
        end
        for (int n = 1; n <= 11; n++) begin
            if (n == 5) begin
                go = 1'b1; mode = 1'b0;
            end
            step();
            clear_inputs();
            n_cmp++;
            if (state !== 3'd1 || count !== 2'(3 - n / 4) || start !== 1'b0) begin
                n_fail++;
                $display("FAIL countdown_digit n=%0d got st=%0d cnt=%0d start=%0b want 1/%0d/0",
                         n, state, count, start, 3 - n / 4);
            end
        end
        step();
        n_cmp++;
        if (state !== 3'd2 || start !== 1'b1 || pause !== 1'b0 || count !== 2'd0) begin
            n_fail++; $display("FAIL play_entry got st=%0d start=%0b pause=%0b cnt=%0d want 2/1/0/0",
                               state, start, pause, count);
        end
        step();
        n_cmp++;
        if (start !== 1'b0) begin
            n_fail++; $display("FAIL start_pulse_width got %0b want 0", start);
        end
    endtask

    task automatic test_attack();
        lines(1'b1, 3'd4, 1'b0, 3'd0);
        n_cmp++;
        if (u_dut.queue_2 !== 4'd4 || req_2 !== 1'b1 || req_1 !== 1'b0) begin
            n_fail++; $display("FAIL attack4 got q2=%0d req2=%0b req1=%0b want 4/1/0", u_dut.queue_2, req_2, req_1);
        end
        for (int i = 1; i <= 5; i++) begin
            ack_2 = 1'b1;
            step();
            clear_inputs();
            n_cmp++;
            if (u_dut.queue_2 !== 4'((i > 4) ? 0 : 4 - i) || req_2 !== (i < 4)) begin
                n_fail++; $display("FAIL ack_drain i=%0d got q2=%0d req2=%0b want %0d/%0b",
                                   i, u_dut.queue_2, req_2, (i > 4) ? 0 : 4 - i, i < 4);
            end
        end
        lines(1'b1, 3'd1, 1'b1, 3'd1);
        n_cmp++;
        if (u_dut.queue_1 !== 4'd0 || u_dut.queue_2 !== 4'd0) begin
            n_fail++; $display("FAIL single_line_attack got q1=%0d q2=%0d want 0/0", u_dut.queue_1, u_dut.queue_2);
        end
    endtask

    task automatic test_cancel_simul();
        lines(1'b0, 3'd0, 1'b1, 3'd3);
        n_cmp++;
        if (u_dut.queue_1 !== 4'd2 || req_1 !== 1'b1) begin
            n_fail++; $display("FAIL p2_attack2 got q1=%0d req1=%0b want 2/1", u_dut.queue_1, req_1);
        end
        lines(1'b1, 3'd3, 1'b0, 3'd0);
        n_cmp++;
        if (u_dut.queue_1 !== 4'd0 || u_dut.queue_2 !== 4'd0) begin
            n_fail++; $display("FAIL full_cancel got q1=%0d q2=%0d want 0/0", u_dut.queue_1, u_dut.queue_2);
        end
        lines(1'b0, 3'd0, 1'b1, 3'd3);
        lines(1'b1, 3'd3, 1'b1, 3'd4);
        n_cmp++;
        if (u_dut.queue_1 !== 4'd4 || u_dut.queue_2 !== 4'd0) begin
            n_fail++; $display("FAIL simultaneous got q1=%0d q2=%0d want 4/0", u_dut.queue_1, u_dut.queue_2);
        end
        ack_1 = 1'b1;
        lines(1'b0, 3'd0, 1'b1, 3'd2);
        n_cmp++;
        if (u_dut.queue_1 !== 4'd4) begin
            n_fail++; $display("FAIL ack_inc_net got q1=%0d want 4", u_dut.queue_1);
        end
        lines(1'b1, 3'd4, 1'b0, 3'd0);
        n_cmp++;
        if (u_dut.queue_1 !== 4'd0 || u_dut.queue_2 !== 4'd0 || req_1 !== 1'b0) begin
            n_fail++; $display("FAIL exact_cancel got q1=%0d q2=%0d req1=%0b want 0/0/0",
                               u_dut.queue_1, u_dut.queue_2, req_1);
        end
    endtask

    task automatic test_saturation();
        repeat (3) lines(1'b1, 3'd4, 1'b0, 3'd0);
        lines(1'b1, 3'd3, 1'b0, 3'd0);
        n_cmp++;
        if (u_dut.queue_2 !== 4'd14) begin
            n_fail++; $display("FAIL build_14 got q2=%0d want 14", u_dut.queue_2);
        end
        lines(1'b1, 3'd4, 1'b0, 3'd0);
        n_cmp++;
        if (u_dut.queue_2 !== 4'd15) begin
            n_fail++; $display("FAIL saturate_first got q2=%0d want 15", u_dut.queue_2);
        end
        lines(1'b1, 3'd4, 1'b0, 3'd0);
        n_cmp++;
        if (u_dut.queue_2 !== 4'd15 || req_2 !== 1'b1) begin
            n_fail++; $display("FAIL saturate_second got q2=%0d req2=%0b want 15/1", u_dut.queue_2, req_2);
        end
    endtask

    task automatic test_pause_over();
        press(8'h76);
        n_cmp++;
        if (state !== 3'd3 || pause !== 1'b1 || req_2 !== 1'b0) begin
            n_fail++; $display("FAIL esc_pause got st=%0d pause=%0b req2=%0b want 3/1/0", state, pause, req_2);
        end
        ack_2 = 1'b1; over_1 = 1'b1;
        lines(1'b0, 3'd0, 1'b1, 3'd4);
        n_cmp++;
        if (state !== 3'd3 || u_dut.queue_2 !== 4'd15 || u_dut.queue_1 !== 4'd0) begin
            n_fail++; $display("FAIL pause_ignores got st=%0d q1=%0d q2=%0d want 3/0/15",
                               state, u_dut.queue_1, u_dut.queue_2);
        end
        press(8'h5A);
        n_cmp++;
        if (state !== 3'd2 || start !== 1'b0 || pause !== 1'b0 || req_2 !== 1'b1) begin
            n_fail++; $display("FAIL resume got st=%0d start=%0b pause=%0b req2=%0b want 2/0/0/1",
                               state, start, pause, req_2);
        end
        over_1 = 1'b1; over_2 = 1'b1;
        step();
        clear_inputs();
        n_cmp++;
        if (state !== 3'd4 || winner !== 2'b11 || pause !== 1'b1) begin
            n_fail++; $display("FAIL draw got st=%0d win=%0d pause=%0b want 4/3/1", state, winner, pause);
        end
        press(8'h5A);
        n_cmp++;
        if (state !== 3'd0 || winner !== 2'b11 || pause !== 1'b0) begin
            n_fail++; $display("FAIL over_to_idle got st=%0d win=%0d pause=%0b want 0/3/0", state, winner, pause);
        end
        go = 1'b1; mode = 1'b0;
        step();
        clear_inputs();
        n_cmp++;
        if (state !== 3'd1 || winner !== 2'b00 || u_dut.queue_2 !== 4'd0) begin
            n_fail++; $display("FAIL go_clears got st=%0d win=%0d q2=%0d want 1/0/0", state, winner, u_dut.queue_2);
        end
    endtask

    task automatic test_single();
        repeat (12) step();
        lines(1'b1, 3'd4, 1'b1, 3'd4);
        over_2 = 1'b1;
        step();
        clear_inputs();
        n_cmp++;
        if (state !== 3'd2 || u_dut.queue_1 !== 4'd0 || u_dut.queue_2 !== 4'd0 || req_2 !== 1'b0) begin
            n_fail++; $display("FAIL single_discard got st=%0d q1=%0d q2=%0d req2=%0b want 2/0/0/0",
                               state, u_dut.queue_1, u_dut.queue_2, req_2);
        end
        over_1 = 1'b1;
        step();
        clear_inputs();
        n_cmp++;
        if (state !== 3'd4 || winner !== 2'b00) begin
            n_fail++; $display("FAIL single_over got st=%0d win=%0d want 4/0", state, winner);
        end
        press(8'h5A);
    endtask

    task automatic test_winner();
        start_match(1'b1);
        over_1 = 1'b1;
        step();
        clear_inputs();
        n_cmp++;
        if (state !== 3'd4 || winner !== 2'b10) begin
            n_fail++; $display("FAIL p1_topout got st=%0d win=%0d want 4/2", state, winner);
        end
        press(8'h5A);
        start_match(1'b1);
        over_2 = 1'b1;
        step();
        clear_inputs();
        n_cmp++;
        if (state !== 3'd4 || winner !== 2'b01) begin
            n_fail++; $display("FAIL p2_topout got st=%0d win=%0d want 4/1", state, winner);
        end
        press(8'h5A);
        start_match(1'b1);
        press(8'h76);
        press(8'h76);
        n_cmp++;
        if (state !== 3'd0 || pause !== 1'b0) begin
            n_fail++; $display("FAIL pause_quit got st=%0d pause=%0b want 0/0", state, pause);
        end
    endtask

    task automatic test_reset_mid();
        go = 1'b1; mode = 1'b1;
        step();
        clear_inputs();
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({state, count, winner, start, pause, req_1, req_2} !== 11'd0 || u_dut.u_queue_1.o_count !== 4'd0) begin
            n_fail++; $display("FAIL reset_mid got st=%0d cnt=%0d win=%0d pause=%0b want all 0",
                               state, count, winner, pause);
        end
        step();
        rst_n = 1'b1;
        go = 1'b1; mode = 1'b1;
        step();
        clear_inputs();
        n_cmp++;
        if (state !== 3'd1 || count !== 2'd3) begin
            n_fail++; $display("FAIL go_after_reset got st=%0d cnt=%0d want 1/3", state, count);
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_attack();
        test_cancel_simul();
        test_saturation();
        test_pause_over();
        test_single();
        test_winner();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
